result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Output-side counterpart of the weight loading path: captures skewed per-column results leaving the bottom edge of the systolic array.
- Column c's result for row r arrives c cycles after column 0's. The block deskews the results into per-column FIFOs.
- Aligned rows are drained to the downstream result sink with a valid/ready handshake.
- A start/done job wrapper counts the expected rows.

Parameters:
COLS, `ARRAYWIDTH, number of array columns (one FIFO lane each)
RES_W, 2*`DATASIZE, width of one result element
DEPTH, 4, entries per column FIFO (power of two, >= 2)
CNT_W, 16, width of the row counters

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a job
num_rows  input  CNT_W  rows expected in the job, sampled on start
in_valid  input  COLS  per-column result strobe from array bottom edge
in_result  input  COLS*RES_W  column c at [(c+1)*RES_W-1 : c*RES_W]
out_valid  output  1  a complete aligned row is presented
out_ready  input  1  downstream accepts the row
out_result  output  COLS*RES_W  aligned row, same column packing as in_result
busy  output  1  job in progress
done  output  1  one-cycle pulse when the last row is accepted
overflow  output  1  sticky flag: a write hit a full column FIFO

Behaviour:
- Reset (synchronous, active-high): state IDLE; all FIFO pointers and counts cleared; row counter = 0.
  - Outputs after reset: out_valid=0, out_result=0, busy=0, done=0, overflow=0.
  - Reset mid-job discards all buffered data and produces no done pulse.
- States: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE when start=1: latch num_rows; clear row counter, FIFOs and overflow.
  - IDLE with start=1 and num_rows=0 -> DONE directly.
  - ACTIVE -> DONE in the cycle after the pop that makes rows_popped == num_rows.
  - DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
- busy = 1 in ACTIVE and DONE; start is ignored when busy=1.
- Column write (ACTIVE only):
  - in_valid[c]=1 pushes in_result column c into FIFO c.
  - in_valid is ignored in IDLE and DONE.
- Full column:
  - A write to a full FIFO is dropped, even if a pop occurs in the same cycle; overflow is set.
  - overflow stays set until the next accepted start or reset.
- FIFOs are show-ahead; write-to-read latency is 1 cycle. Data written at edge t is visible at the head after edge t.
- out_valid = (state==ACTIVE) and all COLS FIFOs non-empty.
- out_result = concatenated FIFO heads while out_valid=1, else 0.
- Pop: out_valid & out_ready pops every column FIFO simultaneously and increments rows_popped.
  - A push and pop on the same non-full column in one cycle are both performed; count is unchanged.
- Stability: out_valid and out_result hold while out_valid=1 and out_ready=0. A later write to a lagging column never alters an already-valid head.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by a per-column count of width log2(DEPTH)+1.
- Rows beyond num_rows:
  - Writes arriving after the last pop are ignored once state leaves ACTIVE.
  - Data still buffered at the DONE transition is flushed on DONE.
- Throughput: one row per cycle sustained when out_ready=1 and the input is fully skewed.

Test Plan:
- Reset check (COLS=4, RES_W=16, DEPTH=4): assert rst for 2 cycles mid-job -> out_valid=0, busy=0, done=0, overflow=0, out_result=0 in the cycle after reset.
- Skewed job, start with num_rows=3, out_ready=1:
  - Stimulus: column c writes rows r=0..2 with value 16'h0100*r+c at cycle 1+r+c.
  - Response: out_valid first at cycle 5 with out_result {16'h0003,16'h0002,16'h0001,16'h0000}; three rows on consecutive cycles; done pulse exactly one cycle after the third pop; busy=0 afterwards.
- Backpressure, same job with out_ready=0 until cycle 10:
  - Response: out_valid=1 from cycle 5 with row 0 held stable.
  - Row 1 requires column 3 to have its 2 entries; at cycle 10 rows pop in order 0,1,2 with no loss; overflow=0.
- Overflow, out_ready=0:
  - Stimulus: 5 writes to column 0 while columns 1..3 stay empty.
  - Response: column 0 holds only the first 4 values; overflow=1 after the 5th write, still 1 after job end, cleared by the next start.
- Edge cases:
  - start with num_rows=0 -> done pulse 1 cycle later; no out_valid.
  - start pulsed while busy -> num_rows unchanged, job completes with the original count.
  - in_valid while IDLE -> no data captured, out_valid stays 0.
- Wrap-around, DEPTH=4, num_rows=10, continuous skewed input, out_ready toggling 1,0,1,0:
  - Response: rows emerge in order with correct values through multiple pointer wraps, and done fires after the 10th pop.

Source files
------------

// File: rtl/result_collector.sv
// Deskews per-column results leaving the bottom edge of the systolic array
// into per-column FIFOs and drains aligned rows to the result sink.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

module result_collector #(
  parameter int COLS  = `ARRAYWIDTH,
  parameter int RES_W = 2 * `DATASIZE,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_rows,
  input  logic [COLS-1:0]       in_valid,
  input  logic [COLS*RES_W-1:0] in_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*RES_W-1:0] out_result,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_rows_q;
  logic [CNT_W-1:0]   rows_popped_q;
  logic               overflow_q;

  logic [RES_W-1:0]   mem    [COLS][DEPTH];
  logic [AW-1:0]      wr_ptr [COLS];
  logic [AW-1:0]      rd_ptr [COLS];
  logic [CW-1:0]      count  [COLS];

  logic [COLS-1:0]    nonempty;
  logic [COLS-1:0]    push;
  logic [COLS-1:0]    drop;
  logic               accept_start;
  logic               pop;
  logic               last_pop;
  logic               flush;

  // A write into a full lane is dropped even when that lane pops this cycle.
  always_comb begin
    nonempty = '0;
    push     = '0;
    drop     = '0;
    for (int c = 0; c < COLS; c++) begin
      nonempty[c] = (count[c] != '0);
      push[c]     = (state_q == ACTIVE) && in_valid[c] && (count[c] != CW'(DEPTH));
      drop[c]     = (state_q == ACTIVE) && in_valid[c] && (count[c] == CW'(DEPTH));
    end
  end

  assign accept_start = (state_q == IDLE) && start;
  assign out_valid    = (state_q == ACTIVE) && (&nonempty);
  assign pop          = out_valid && out_ready;
  assign last_pop     = pop && ((rows_popped_q + CNT_W'(1)) == num_rows_q);
  assign flush        = accept_start || (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign overflow     = overflow_q;

  always_comb begin
    out_result = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++)
        out_result[c*RES_W +: RES_W] = mem[c][rd_ptr[c]];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_rows == '0) ? DONE : ACTIVE;
      ACTIVE:  if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_rows_q    <= '0;
      rows_popped_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        num_rows_q    <= num_rows;
        rows_popped_q <= '0;
        overflow_q    <= 1'b0;
      end else begin
        if (pop)   rows_popped_q <= rows_popped_q + CNT_W'(1);
        if (|drop) overflow_q    <= 1'b1;
      end
    end
  end

  // Leftover rows are discarded both when a new job starts and on DONE.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (rst || flush) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end else begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop)     rd_ptr[c] <= rd_ptr[c] + AW'(1);
        count[c] <= count[c] + CW'(push[c]) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= in_result[c*RES_W +: RES_W];
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed job scenarios plus randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_result_collector;
  localparam int COLS  = 4;
  localparam int RES_W = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [CNT_W-1:0]      num_rows;
  logic [COLS-1:0]       in_valid;
  logic [COLS*RES_W-1:0] in_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLS*RES_W-1:0] out_result;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  always #5 clk = ~clk;

  result_collector #(.COLS(COLS), .RES_W(RES_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_result(in_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .busy(busy),
    .done(done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: job phase (0 idle, 1 active, 2 done) and one queue per column.
  int          m_phase = 0;
  int          m_target = 0;
  int          m_popped = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] mq [4][$];

  logic        obs_valid, obs_busy, obs_done, obs_ovf;
  logic [63:0] obs_result;

  int          first_valid, done_cyc, pops, n_done;
  logic [63:0] first_res, c0_hist;
  logic [3:0]  v;
  logic [63:0] d;
  logic        ovf_mark;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [15:0] n,
                               input logic [3:0] vv, input logic [63:0] dd, input logic rdy);
    logic        ev;
    logic [63:0] er;
    bit          full_pre [4];
    @(negedge clk);
    rst = r; start = s; num_rows = n; in_valid = vv; in_result = dd; out_ready = rdy;
    #1;
    ev = (m_phase == 1);
    for (int c = 0; c < 4; c++) if (mq[c].size() == 0) ev = 1'b0;
    er = '0;
    if (ev) for (int c = 0; c < 4; c++) er[c*16 +: 16] = mq[c][0];
    if (chk_en) begin
      checkOutput("out_valid",  64'(out_valid), 64'(ev));
      checkOutput("out_result", out_result, er);
      checkOutput("busy",       64'(busy), 64'(m_phase != 0));
      checkOutput("done",       64'(done), 64'(m_phase == 2));
      checkOutput("overflow",   64'(overflow), 64'(m_ovf));
    end
    obs_valid = out_valid; obs_result = out_result; obs_busy = busy;
    obs_done = done; obs_ovf = overflow;
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_popped = 0; m_ovf = 1'b0;
      for (int c = 0; c < 4; c++) mq[c].delete();
    end else begin
      case (m_phase)
        0: if (s) begin
             for (int c = 0; c < 4; c++) mq[c].delete();
             m_ovf = 1'b0; m_target = int'(n); m_popped = 0;
             m_phase = (n == 0) ? 2 : 1;
           end
        1: begin
             for (int c = 0; c < 4; c++) full_pre[c] = (mq[c].size() == DEPTH);
             if (ev && rdy) begin
               for (int c = 0; c < 4; c++) void'(mq[c].pop_front());
               m_popped++;
             end
             for (int c = 0; c < 4; c++) begin
               if (vv[c]) begin
                 if (full_pre[c]) m_ovf = 1'b1;
                 else mq[c].push_back(dd[c*16 +: 16]);
               end
             end
             if (ev && rdy && m_popped == m_target) m_phase = 2;
           end
        default: begin
             for (int c = 0; c < 4; c++) mq[c].delete();
             m_phase = 0;
           end
      endcase
    end
  endtask

  // Column c carries row r at cycle 1 + stride*r + c, value 16'h0100*r + c.
  task automatic skew(input int k, input int rows, input int stride,
                      output logic [3:0] vv, output logic [63:0] dd);
    int off;
    vv = '0; dd = '0;
    for (int c = 0; c < 4; c++) begin
      off = k - 1 - c;
      if (off >= 0 && off % stride == 0 && off / stride < rows) begin
        vv[c] = 1'b1;
        dd[c*16 +: 16] = 16'(16'h0100 * (off / stride) + c);
      end
    end
  endtask

  task automatic resetTrack();
    first_valid = -1; done_cyc = -1; pops = 0; n_done = 0;
    first_res = '0; c0_hist = '0;
  endtask

  task automatic track(input int k, input logic rdy);
    if (obs_valid && first_valid < 0) begin first_valid = k; first_res = obs_result; end
    if (obs_valid && rdy) begin pops++; c0_hist = {c0_hist[47:0], obs_result[15:0]}; end
    if (obs_done) begin n_done++; if (done_cyc < 0) done_cyc = k; end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Skewed job with the sink always ready.
    resetTrack();
    for (int k = 0; k < 12; k++) begin
      skew(k, 3, 1, v, d);
      applyStimulus(0, k == 0, 16'd3, v, d, 1'b1);
      track(k, 1'b1);
    end
    checkOutput("skew_first_valid_cycle", 64'(first_valid), 64'd5);
    checkOutput("skew_first_row", first_res, 64'h0003_0002_0001_0000);
    checkOutput("skew_pops", 64'(pops), 64'd3);
    checkOutput("skew_done_cycle", 64'(done_cyc), 64'd8);
    checkOutput("skew_busy_after", 64'(obs_busy), 64'd0);

    // Same job, sink stalled until cycle 10.
    resetTrack();
    for (int k = 0; k < 16; k++) begin
      skew(k, 3, 1, v, d);
      applyStimulus(0, k == 0, 16'd3, v, d, k >= 10);
      track(k, k >= 10);
    end
    checkOutput("bp_first_valid_cycle", 64'(first_valid), 64'd5);
    checkOutput("bp_pops", 64'(pops), 64'd3);
    checkOutput("bp_done_cycle", 64'(done_cyc), 64'd13);
    checkOutput("bp_overflow", 64'(obs_ovf), 64'd0);

    // Column 0 overfilled while the other lanes are still empty.
    resetTrack();
    ovf_mark = 1'b0;
    for (int k = 0; k < 16; k++) begin
      v = '0; d = '0;
      if (k >= 1 && k <= 5) begin v[0] = 1'b1; d[15:0] = 16'(16'hA000 + k - 1); end
      if (k >= 6 && k <= 9)
        for (int c = 1; c < 4; c++) begin v[c] = 1'b1; d[c*16 +: 16] = 16'(16'hB000 + c*16 + k - 6); end
      applyStimulus(0, k == 0, 16'd4, v, d, k >= 8);
      track(k, k >= 8);
      if (k == 6) ovf_mark = obs_ovf;
    end
    checkOutput("ovf_set", 64'(ovf_mark), 64'd1);
    checkOutput("ovf_col0_rows", c0_hist, 64'hA000_A001_A002_A003);
    checkOutput("ovf_done_cycle", 64'(done_cyc), 64'd12);
    checkOutput("ovf_sticky_after_job", 64'(obs_ovf), 64'd1);

    // Zero-row job; its start also clears the sticky overflow.
    resetTrack();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, k == 0, 16'd0, 4'hF, 64'h1111_2222_3333_4444, 1'b1);
      track(k, 1'b1);
      if (k == 1) ovf_mark = obs_ovf;
    end
    checkOutput("zero_done_cycle", 64'(done_cyc), 64'd1);
    checkOutput("zero_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("zero_ovf_cleared", 64'(ovf_mark), 64'd0);

    // Second start while busy must not change the row count.
    resetTrack();
    for (int k = 0; k < 12; k++) begin
      skew(k, 4, 1, v, d);
      applyStimulus(0, k == 0 || k == 3, (k == 3) ? 16'd7 : 16'd2, v, d, 1'b1);
      track(k, 1'b1);
    end
    checkOutput("busy_start_pops", 64'(pops), 64'd2);
    checkOutput("busy_start_done_cycle", 64'(done_cyc), 64'd7);
    checkOutput("busy_start_done_count", 64'(n_done), 64'd1);

    // Ten rows through depth-4 lanes with the sink toggling.
    resetTrack();
    for (int k = 0; k < 28; k++) begin
      skew(k, 10, 2, v, d);
      applyStimulus(0, k == 0, 16'd10, v, d, (k % 2) == 0);
      track(k, (k % 2) == 0);
    end
    checkOutput("wrap_pops", 64'(pops), 64'd10);
    checkOutput("wrap_done_cycle", 64'(done_cyc), 64'd25);
    checkOutput("wrap_last_col0", c0_hist[15:0], 64'h0900);
    checkOutput("wrap_overflow", 64'(obs_ovf), 64'd0);

    // Writes while idle, then a reset in the middle of an overflowing job.
    resetTrack();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 16'd0, 4'hF, {$urandom(), $urandom()}, 1'b1);
      track(k, 1'b1);
    end
    checkOutput("idle_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, k == 0, 16'd1, (k >= 1 && k <= 5) ? 4'h1 : 4'h0, 64'(16'hC000 + k), 1'b0);
      if (k == 6) ovf_mark = obs_ovf;
    end
    checkOutput("midjob_ovf_before_reset", 64'(ovf_mark), 64'd1);
    applyStimulus(1, 1, 16'd5, 4'hF, 64'hFFFF, 1'b1);
    applyStimulus(1, 0, 16'd5, 4'hF, 64'hFFFF, 1'b1);
    applyStimulus(0, 0, 16'd0, 4'h0, 64'h0, 1'b1);
    checkOutput("rst_out_valid", 64'(obs_valid), 64'd0);
    checkOutput("rst_out_result", obs_result, 64'd0);
    checkOutput("rst_busy", 64'(obs_busy), 64'd0);
    checkOutput("rst_done", 64'(obs_done), 64'd0);
    checkOutput("rst_overflow", 64'(obs_ovf), 64'd0);

    // Randomized jobs with stray starts, random writes and random backpressure.
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 40; k++) begin
        applyStimulus(0, (k == 0) || ($urandom_range(0, 15) == 0),
                      16'($urandom_range(0, 6)), 4'($urandom()),
                      {$urandom(), $urandom()}, $urandom_range(0, 3) != 0);
      end
      applyStimulus(1, 0, 16'd0, 4'($urandom()), 64'h0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
